// File: rtl/operational_memory_arb.sv
// rtl/operational_memory_arb.sv - single-write dual-reader game-state store with GL/ED read-port ownership (optional macro: OPMEM_WR_BYPASS_EN)
module operational_memory_arb #(
   parameter int    DATA_W    = 11,
   parameter int    STORE_W   = 16,
   parameter int    DEPTH     = 128,
   parameter string INIT_FILE = "op_memory.mif",
   localparam int   ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address_write,
   input  logic [DATA_W-1:0] data_write,
   input  logic              wren,
   input  logic              next_screen,
   input  logic              new_state,
   input  logic              rd_req_gl,
   input  logic [ADDR_W-1:0] address_read_gl,
   output logic              rd_gnt_gl,
   output logic [DATA_W-1:0] data_read_gl,
   output logic              rd_valid_gl,
   input  logic              rd_req_ed,
   input  logic [ADDR_W-1:0] address_read_ed,
   output logic              rd_gnt_ed,
   output logic [DATA_W-1:0] data_read_ed,
   output logic              rd_valid_ed,
   output logic              owner_gl
);

   typedef enum logic {
      ED_OWN = 1'b0,
      GL_OWN = 1'b1
   } state_t;

   // Array contents come from INIT_FILE through the RAM inference flow; reset never touches them.
   localparam string init_file_unused = INIT_FILE;

   // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [STORE_W-1:0] r_mem [DEPTH];

   state_t             r_state;
   state_t             w_state_nxt;

   logic               w_wr_ok;
   logic               w_gl_in_range;
   logic               w_ed_in_range;
   logic               w_gnt_gl;
   logic               w_gnt_ed;
   logic [STORE_W-1:0] w_word_gl;
   logic [STORE_W-1:0] w_word_ed;
   logic [DATA_W-1:0]  w_rd_data_gl;
   logic [DATA_W-1:0]  w_rd_data_ed;
   logic               w_pad_unused;

   logic [DATA_W-1:0]  r_data_gl;
   logic [DATA_W-1:0]  r_data_ed;
   logic               r_valid_gl;
   logic               r_valid_ed;

   assign w_wr_ok       = wren && ({1'b0, address_write} < DEPTH_L);
   assign w_gl_in_range = {1'b0, address_read_gl} < DEPTH_L;
   assign w_ed_in_range = {1'b0, address_read_ed} < DEPTH_L;

   // Out-of-range reads return zero but still complete a normal handshake.
   assign w_word_gl = w_gl_in_range ? r_mem[address_read_gl] : '0;
   assign w_word_ed = w_ed_in_range ? r_mem[address_read_ed] : '0;

   // Pad bits above DATA_W are always written as zero and never returned.
   assign w_pad_unused = ^{w_word_gl, w_word_ed};

   // Grants follow the registered owner, so an ownership pulse only affects the next cycle.
   assign w_gnt_gl = rd_req_gl && (r_state == GL_OWN);
   assign w_gnt_ed = rd_req_ed && (r_state == ED_OWN);

`ifdef OPMEM_WR_BYPASS_EN
   // Write-first: a same-address write in the grant cycle is forwarded to the reader.
   always_comb begin
      w_rd_data_gl = w_word_gl[DATA_W-1:0];
      w_rd_data_ed = w_word_ed[DATA_W-1:0];
      if (w_wr_ok && (address_write == address_read_gl)) begin
         w_rd_data_gl = data_write;
      end
      if (w_wr_ok && (address_write == address_read_ed)) begin
         w_rd_data_ed = data_write;
      end
   end
`else
   // Read-before-write: the array is sampled before the same-edge write lands.
   always_comb begin
      w_rd_data_gl = w_word_gl[DATA_W-1:0];
      w_rd_data_ed = w_word_ed[DATA_W-1:0];
   end
`endif

   // Single write port, never blocked by read ownership.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[address_write] <= STORE_W'(data_write);
      end
   end

   // Ownership state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ED_OWN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ownership next-state: new_state beats next_screen when both arrive together.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ED_OWN: begin
            if (next_screen && !new_state) begin
               w_state_nxt = GL_OWN;
            end
         end
         GL_OWN: begin
            if (new_state) begin
               w_state_nxt = ED_OWN;
            end
         end
         default: w_state_nxt = ED_OWN;
      endcase
   end

   // GL read data register and valid pulse, loaded on the edge that closes the grant cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_gl <= 1'b0;
         r_data_gl  <= '0;
      end else begin
         r_valid_gl <= w_gnt_gl;
         if (w_gnt_gl) begin
            r_data_gl <= w_rd_data_gl;
         end
      end
   end

   // ED read data register and valid pulse, loaded on the edge that closes the grant cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_ed <= 1'b0;
         r_data_ed  <= '0;
      end else begin
         r_valid_ed <= w_gnt_ed;
         if (w_gnt_ed) begin
            r_data_ed <= w_rd_data_ed;
         end
      end
   end

   assign rd_gnt_gl    = w_gnt_gl;
   assign rd_gnt_ed    = w_gnt_ed;
   assign data_read_gl = r_data_gl;
   assign data_read_ed = r_data_ed;
   assign rd_valid_gl  = r_valid_gl;
   assign rd_valid_ed  = r_valid_ed;
   assign owner_gl     = (r_state == GL_OWN);

endmodule

// File: tb/tb_operational_memory_arb.sv
// tb/tb_operational_memory_arb.sv - scoreboard bench for operational_memory_arb (DEPTH=100)
module tb_operational_memory_arb;

   localparam int DW = 11;
   localparam int AW = 7;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] address_write;
   logic [DW-1:0] data_write;
   logic          wren;
   logic          next_screen;
   logic          new_state;
   logic          rd_req_gl;
   logic [AW-1:0] address_read_gl;
   logic          rd_gnt_gl;
   logic [DW-1:0] data_read_gl;
   logic          rd_valid_gl;
   logic          rd_req_ed;
   logic [AW-1:0] address_read_ed;
   logic          rd_gnt_ed;
   logic [DW-1:0] data_read_ed;
   logic          rd_valid_ed;
   logic          owner_gl;

   int            checks;
   int            failures;
   logic [DW-1:0] q_gl[$];
   logic [DW-1:0] q_ed[$];

   operational_memory_arb #(
      .DATA_W (11),
      .STORE_W(16),
      .DEPTH  (100)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .address_write  (address_write),
      .data_write     (data_write),
      .wren           (wren),
      .next_screen    (next_screen),
      .new_state      (new_state),
      .rd_req_gl      (rd_req_gl),
      .address_read_gl(address_read_gl),
      .rd_gnt_gl      (rd_gnt_gl),
      .data_read_gl   (data_read_gl),
      .rd_valid_gl    (rd_valid_gl),
      .rd_req_ed      (rd_req_ed),
      .address_read_ed(address_read_ed),
      .rd_gnt_ed      (rd_gnt_ed),
      .data_read_ed   (data_read_ed),
      .rd_valid_ed    (rd_valid_ed),
      .owner_gl       (owner_gl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wren = 1'b1; address_write = a; data_write = d;
      tick();
      wren = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (owner_gl !== 1'b0) begin failures++; $display("FAIL reset_owner actual=%0b required=0", owner_gl); end
      checks++; if (rd_valid_gl !== 1'b0) begin failures++; $display("FAIL reset_valid_gl actual=%0b required=0", rd_valid_gl); end
      checks++; if (rd_valid_ed !== 1'b0) begin failures++; $display("FAIL reset_valid_ed actual=%0b required=0", rd_valid_ed); end
      checks++; if (data_read_gl !== 11'h0) begin failures++; $display("FAIL reset_data_gl actual=%h required=000", data_read_gl); end
      checks++; if (data_read_ed !== 11'h0) begin failures++; $display("FAIL reset_data_ed actual=%h required=000", data_read_ed); end
      rst_n = 1'b1;
      tick();
      // Preload, then reset again: the array must survive reset.
      wr(7'd5, 11'h2A5);
      wr(7'd7, 11'h155);
      wr(7'd3, 11'h0AB);
      wr(7'd20, 11'h3C3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ed_read();
      logic [DW-1:0] exp;
      rd_req_ed = 1'b1; address_read_ed = 7'd5;
      q_ed.push_back(11'h2A5);
      #1;
      checks++; if (rd_gnt_ed !== 1'b1) begin failures++; $display("FAIL t1_gnt_ed actual=%0b required=1", rd_gnt_ed); end
      checks++; if (rd_gnt_gl !== 1'b0) begin failures++; $display("FAIL t1_gnt_gl actual=%0b required=0", rd_gnt_gl); end
      tick();
      rd_req_ed = 1'b0;
      checks++; if (rd_valid_ed !== 1'b1) begin failures++; $display("FAIL t1_valid_ed actual=%0b required=1", rd_valid_ed); end
      exp = q_ed.pop_front();
      checks++; if (data_read_ed !== exp) begin failures++; $display("FAIL t1_data_ed actual=%h required=%h", data_read_ed, exp); end
      tick();
      checks++; if (rd_valid_ed !== 1'b0) begin failures++; $display("FAIL t1_valid_pulse actual=%0b required=0", rd_valid_ed); end
      checks++; if (data_read_ed !== 11'h2A5) begin failures++; $display("FAIL t1_data_hold actual=%h required=2a5", data_read_ed); end
   endtask

   task automatic test_gl_switch();
      logic [DW-1:0] exp;
      next_screen = 1'b1; rd_req_gl = 1'b1; address_read_gl = 7'd7;
      #1;
      checks++; if (rd_gnt_gl !== 1'b0) begin failures++; $display("FAIL t2_gnt_same_cycle actual=%0b required=0", rd_gnt_gl); end
      checks++; if (owner_gl !== 1'b0) begin failures++; $display("FAIL t2_owner_before actual=%0b required=0", owner_gl); end
      tick();
      next_screen = 1'b0;
      q_gl.push_back(11'h155);
      #1;
      checks++; if (owner_gl !== 1'b1) begin failures++; $display("FAIL t2_owner_after actual=%0b required=1", owner_gl); end
      checks++; if (rd_gnt_gl !== 1'b1) begin failures++; $display("FAIL t2_gnt_gl actual=%0b required=1", rd_gnt_gl); end
      checks++; if (rd_valid_gl !== 1'b0) begin failures++; $display("FAIL t2_no_early_valid actual=%0b required=0", rd_valid_gl); end
      tick();
      rd_req_gl = 1'b0;
      checks++; if (rd_valid_gl !== 1'b1) begin failures++; $display("FAIL t2_valid_gl actual=%0b required=1", rd_valid_gl); end
      exp = q_gl.pop_front();
      checks++; if (data_read_gl !== exp) begin failures++; $display("FAIL t2_data_gl actual=%h required=%h", data_read_gl, exp); end
      rd_req_ed = 1'b1; address_read_ed = 7'd5;
      #1;
      checks++; if (rd_gnt_ed !== 1'b0) begin failures++; $display("FAIL t2_ed_blocked actual=%0b required=0", rd_gnt_ed); end
      rd_req_ed = 1'b0;
      tick();
   endtask

   task automatic test_both_pulses();
      next_screen = 1'b1; new_state = 1'b1;
      tick();
      next_screen = 1'b0; new_state = 1'b0;
      checks++; if (owner_gl !== 1'b0) begin failures++; $display("FAIL t3_owner_gl_to_ed actual=%0b required=0", owner_gl); end
      rd_req_gl = 1'b1; address_read_gl = 7'd7;
      #1;
      checks++; if (rd_gnt_gl !== 1'b0) begin failures++; $display("FAIL t3_gl_stall actual=%0b required=0", rd_gnt_gl); end
      tick();
      checks++; if (rd_valid_gl !== 1'b0) begin failures++; $display("FAIL t3_no_valid actual=%0b required=0", rd_valid_gl); end
      rd_req_gl = 1'b0;
      next_screen = 1'b1; new_state = 1'b1;
      tick();
      next_screen = 1'b0; new_state = 1'b0;
      checks++; if (owner_gl !== 1'b0) begin failures++; $display("FAIL t3_owner_stay_ed actual=%0b required=0", owner_gl); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp;
      wren = 1'b1; address_write = 7'd3; data_write = 11'h7FF;
      rd_req_ed = 1'b1; address_read_ed = 7'd3;
`ifdef OPMEM_WR_BYPASS_EN
      q_ed.push_back(11'h7FF);
`else
      q_ed.push_back(11'h0AB);
`endif
      #1;
      checks++; if (rd_gnt_ed !== 1'b1) begin failures++; $display("FAIL t4_gnt_first actual=%0b required=1", rd_gnt_ed); end
      tick();
      wren = 1'b0;
      q_ed.push_back(11'h7FF);
      checks++; if (rd_valid_ed !== 1'b1) begin failures++; $display("FAIL t4_valid_first actual=%0b required=1", rd_valid_ed); end
      exp = q_ed.pop_front();
      checks++; if (data_read_ed !== exp) begin failures++; $display("FAIL t4_rw_collision actual=%h required=%h", data_read_ed, exp); end
      tick();
      rd_req_ed = 1'b0;
      checks++; if (rd_valid_ed !== 1'b1) begin failures++; $display("FAIL t4_valid_second actual=%0b required=1", rd_valid_ed); end
      exp = q_ed.pop_front();
      checks++; if (data_read_ed !== exp) begin failures++; $display("FAIL t4_after_write actual=%h required=%h", data_read_ed, exp); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      next_screen = 1'b1;
      tick();
      next_screen = 1'b0;
      checks++; if (owner_gl !== 1'b1) begin failures++; $display("FAIL t5_owner_gl actual=%0b required=1", owner_gl); end
      rd_req_gl = 1'b1; address_read_gl = 7'd5;
      #1;
      checks++; if (rd_gnt_gl !== 1'b1) begin failures++; $display("FAIL t5_gnt_gl actual=%0b required=1", rd_gnt_gl); end
      rst_n = 1'b0;
      #1;
      checks++; if (owner_gl !== 1'b0) begin failures++; $display("FAIL t5_owner_reset actual=%0b required=0", owner_gl); end
      checks++; if (data_read_gl !== 11'h0) begin failures++; $display("FAIL t5_data_gl actual=%h required=000", data_read_gl); end
      checks++; if (data_read_ed !== 11'h0) begin failures++; $display("FAIL t5_data_ed actual=%h required=000", data_read_ed); end
      tick();
      checks++; if (rd_valid_gl !== 1'b0) begin failures++; $display("FAIL t5_valid_dropped actual=%0b required=0", rd_valid_gl); end
      checks++; if (data_read_gl !== 11'h0) begin failures++; $display("FAIL t5_no_update actual=%h required=000", data_read_gl); end
      rd_req_gl = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++; if (rd_valid_gl !== 1'b0 || rd_valid_ed !== 1'b0) begin failures++; $display("FAIL t5_valid_after actual=%0b%0b required=00", rd_valid_gl, rd_valid_ed); end
   endtask

   task automatic test_out_of_range();
      logic [DW-1:0] exp;
      rd_req_ed = 1'b1; address_read_ed = 7'd20;
      q_ed.push_back(11'h3C3);
      tick();
      checks++; if (rd_valid_ed !== 1'b1) begin failures++; $display("FAIL t6_valid_20 actual=%0b required=1", rd_valid_ed); end
      exp = q_ed.pop_front();
      checks++; if (data_read_ed !== exp) begin failures++; $display("FAIL t6_data_20 actual=%h required=%h", data_read_ed, exp); end
      address_read_ed = 7'd120;
      wren = 1'b1; address_write = 7'd120; data_write = 11'h111;
      q_ed.push_back(11'h000);
      #1;
      checks++; if (rd_gnt_ed !== 1'b1) begin failures++; $display("FAIL t6_gnt_120 actual=%0b required=1", rd_gnt_ed); end
      tick();
      wren = 1'b0;
      address_read_ed = 7'd20;
      q_ed.push_back(11'h3C3);
      checks++; if (rd_valid_ed !== 1'b1) begin failures++; $display("FAIL t6_valid_120 actual=%0b required=1", rd_valid_ed); end
      exp = q_ed.pop_front();
      checks++; if (data_read_ed !== exp) begin failures++; $display("FAIL t6_data_120 actual=%h required=%h", data_read_ed, exp); end
      tick();
      rd_req_ed = 1'b0;
      checks++; if (rd_valid_ed !== 1'b1) begin failures++; $display("FAIL t6_valid_20b actual=%0b required=1", rd_valid_ed); end
      exp = q_ed.pop_front();
      checks++; if (data_read_ed !== exp) begin failures++; $display("FAIL t6_no_corrupt actual=%h required=%h", data_read_ed, exp); end
      tick();
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; wren = 1'b0; address_write = '0; data_write = '0;
      next_screen = 1'b0; new_state = 1'b0;
      rd_req_gl = 1'b0; address_read_gl = '0;
      rd_req_ed = 1'b0; address_read_ed = '0;
      test_reset();
      test_ed_read();
      test_gl_switch();
      test_both_pulses();
      test_back_to_back();
      test_reset_mid_read();
      test_out_of_range();
      checks++;
      if (q_gl.size() != 0 || q_ed.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", q_gl.size(), q_ed.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
